// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected MAC arbiter: FSM state
// encoding and default bus widths.
package fc_pkg;

  // Default widths of the requester and datapath buses
  localparam int FC_W_ADDR_W = 9;
  localparam int FC_D_ADDR_W = 4;
  localparam int FC_BSEL_W   = 4;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_OWN0 = 3'b010,
    ST_OWN1 = 3'b100
  } arb_state_e;

endpackage

// File: rtl/fc_mac_arbiter_if.sv
// Bundle of requester-side and datapath-side signals around the shared
// MAC arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and readys.
interface fc_mac_arbiter_if
  import fc_pkg::*;
#(
  parameter int W_ADDR_W = FC_W_ADDR_W,
  parameter int D_ADDR_W = FC_D_ADDR_W,
  parameter int BSEL_W   = FC_BSEL_W
);
  logic                req0, req1;
  logic                gnt0, gnt1;
  logic [W_ADDR_W-1:0] waddr0, waddr1;
  logic [D_ADDR_W-1:0] daddr0, daddr1;
  logic                dvalid0, dvalid1;
  logic                dsel0, dsel1;
  logic                bvalid0, bvalid1;
  logic [BSEL_W-1:0]   bsel0, bsel1;
  logic                mac_ready0, mac_ready1;
  logic                bias_ready0, bias_ready1;
  logic [W_ADDR_W-1:0] weight_addr;
  logic [D_ADDR_W-1:0] data_addr;
  logic                data_valid;
  logic                data_sel;
  logic                bias_valid;
  logic [BSEL_W-1:0]   bias_sel;
  logic                mac_ready;
  logic                bias_ready;
  logic                owner;
  logic                err;
  logic                err_clr;

  modport slave (
    input  req0, req1, waddr0, waddr1, daddr0, daddr1, dvalid0, dvalid1,
           dsel0, dsel1, bvalid0, bvalid1, bsel0, bsel1, mac_ready, bias_ready,
           err_clr,
    output gnt0, gnt1, mac_ready0, mac_ready1, bias_ready0, bias_ready1,
           weight_addr, data_addr, data_valid, data_sel, bias_valid, bias_sel,
           owner, err
  );

  modport master (
    output req0, req1, waddr0, waddr1, daddr0, daddr1, dvalid0, dvalid1,
           dsel0, dsel1, bvalid0, bvalid1, bsel0, bsel1, mac_ready, bias_ready,
           err_clr,
    input  gnt0, gnt1, mac_ready0, mac_ready1, bias_ready0, bias_ready1,
           weight_addr, data_addr, data_valid, data_sel, bias_valid, bias_sel,
           owner, err
  );

endinterface

// File: rtl/fc_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester that
// was not served last wins.
module fc_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic idx
);

  // Tie goes to the requester other than 'last'; otherwise the lone requester
  always_comb begin
    valid = req0 | req1;
    idx   = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/fc_mac_arbiter.sv
// Per-neuron round-robin arbiter sharing one MAC/bias/activation datapath
// between the L1 (requester 0) and L2 (requester 1) controllers.
// Optional idle-grant watchdog: define FC_ARB_TIMEOUT_EN.
module fc_mac_arbiter
  import fc_pkg::*;
#(
  parameter int W_ADDR_W    = FC_W_ADDR_W,
  parameter int D_ADDR_W    = FC_D_ADDR_W,
  parameter int BSEL_W      = FC_BSEL_W,
  parameter int TIMEOUT_CYC = 64
)(
  input  logic               clk,
  input  logic               rst_n,
  fc_mac_arbiter_if.slave    bus
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("fc_mac_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  arb_state_e          r_state, w_state_next;
  logic                r_owner;
  logic                w_pick_valid, w_pick_idx;
  logic                w_own;
  logic                w_wd_expire;
  logic                w_err;
  logic [W_ADDR_W-1:0] w_weight_addr;
  logic [D_ADDR_W-1:0] w_data_addr;
  logic [BSEL_W-1:0]   w_bias_sel;

  assign w_own = (r_state == ST_OWN0) || (r_state == ST_OWN1);

  fc_rr_pick2 u_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (r_owner),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

`ifdef FC_ARB_TIMEOUT_EN
  logic [7:0] r_wd_cnt;
  logic       r_err;
  logic       w_stall;

  assign w_stall     = w_own & ~bus.mac_ready & ~bus.bias_ready;
  assign w_wd_expire = w_stall && (r_wd_cnt == 8'(TIMEOUT_CYC - 1));
  assign w_err       = r_err;

  // Count consecutive owned cycles with no datapath progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wd_cnt <= '0;
    else if (!w_stall || w_wd_expire)
      r_wd_cnt <= '0;
    else
      r_wd_cnt <= r_wd_cnt + 8'd1;
  end

  // Sticky error flag; a fresh expiry wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_wd_expire)
      r_err <= 1'b1;
    else if (bus.err_clr)
      r_err <= 1'b0;
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign w_wd_expire      = 1'b0;
  assign w_err            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Grant from IDLE via round-robin pick; release on neuron end, abort or expiry
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_valid) w_state_next = w_pick_idx ? ST_OWN1 : ST_OWN0;
      ST_OWN0: if (bus.bias_ready || !bus.req0 || w_wd_expire) w_state_next = ST_IDLE;
      ST_OWN1: if (bus.bias_ready || !bus.req1 || w_wd_expire) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Remember who was granted last; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_owner <= 1'b1;
    else if (r_state == ST_IDLE && w_pick_valid)
      r_owner <= w_pick_idx;
  end

  // Steer the owner's address/strobe signals to the datapath; zeros when idle
  always_comb begin
    w_weight_addr  = '0;
    w_data_addr    = '0;
    w_bias_sel     = '0;
    bus.data_valid = 1'b0;
    bus.data_sel   = 1'b0;
    bus.bias_valid = 1'b0;
    case (r_state)
      ST_OWN0: begin
        w_weight_addr  = bus.waddr0;
        w_data_addr    = bus.daddr0;
        w_bias_sel     = bus.bsel0;
        bus.data_valid = bus.dvalid0;
        bus.data_sel   = bus.dsel0;
        bus.bias_valid = bus.bvalid0;
      end
      ST_OWN1: begin
        w_weight_addr  = bus.waddr1;
        w_data_addr    = bus.daddr1;
        w_bias_sel     = bus.bsel1;
        bus.data_valid = bus.dvalid1;
        bus.data_sel   = bus.dsel1;
        bus.bias_valid = bus.bvalid1;
      end
      default: ;
    endcase
  end

  // Grants and readys routed back only to the current owner
  always_comb begin
    bus.gnt0        = (r_state == ST_OWN0);
    bus.gnt1        = (r_state == ST_OWN1);
    bus.mac_ready0  = bus.mac_ready  & (r_state == ST_OWN0);
    bus.mac_ready1  = bus.mac_ready  & (r_state == ST_OWN1);
    bus.bias_ready0 = bus.bias_ready & (r_state == ST_OWN0);
    bus.bias_ready1 = bus.bias_ready & (r_state == ST_OWN1);
  end

  assign bus.weight_addr = w_weight_addr;
  assign bus.data_addr   = w_data_addr;
  assign bus.bias_sel    = w_bias_sel;
  assign bus.owner       = r_owner;
  assign bus.err         = w_err;

endmodule

// File: tb/tb_fc_mac_arbiter.sv
// Directed self-checking bench for fc_mac_arbiter. The watchdog scenario
// is exercised only when FC_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_fc_mac_arbiter;
  import fc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  fc_mac_arbiter_if #(.W_ADDR_W(9), .D_ADDR_W(4), .BSEL_W(4)) bus ();

  fc_mac_arbiter #(
    .W_ADDR_W(9), .D_ADDR_W(4), .BSEL_W(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.waddr0 = '0; bus.waddr1 = '0; bus.daddr0 = '0; bus.daddr1 = '0;
    bus.dvalid0 = 0; bus.dvalid1 = 0; bus.dsel0 = 0; bus.dsel1 = 0;
    bus.bvalid0 = 0; bus.bvalid1 = 0; bus.bsel0 = '0; bus.bsel1 = '0;
    bus.mac_ready = 0; bus.bias_ready = 0; bus.err_clr = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.mac_ready = 1; bus.bias_ready = 1; bus.waddr0 = 9'd5;
    tick(); tick();
    n_cmp++; if ({bus.gnt1, bus.gnt0} !== 2'b00) begin n_mis++; $display("FAIL reset_gnt: got %b expected 00", {bus.gnt1, bus.gnt0}); end
    n_cmp++; if (bus.owner !== 1'b1) begin n_mis++; $display("FAIL reset_owner: got %b expected 1", bus.owner); end
    n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.weight_addr !== 9'd0 || bus.data_valid !== 1'b0 || bus.bias_valid !== 1'b0)
      begin n_mis++; $display("FAIL reset_mux: got waddr=%0d dv=%b bv=%b expected 0 0 0", bus.weight_addr, bus.data_valid, bus.bias_valid); end
    n_cmp++; if ({bus.mac_ready1, bus.mac_ready0, bus.bias_ready1, bus.bias_ready0} !== 4'b0000)
      begin n_mis++; $display("FAIL reset_readys: got %b expected 0000", {bus.mac_ready1, bus.mac_ready0, bus.bias_ready1, bus.bias_ready0}); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_grant();
    bus.req0 = 1; bus.waddr0 = 9'd27; bus.daddr0 = 4'd5; bus.dvalid0 = 1;
    #1;
    n_cmp++; if (bus.gnt0 !== 1'b0) begin n_mis++; $display("FAIL single_pre_gnt: got %b expected 0", bus.gnt0); end
    tick();
    n_cmp++; if (bus.gnt0 !== 1'b1) begin n_mis++; $display("FAIL single_gnt0: got %b expected 1", bus.gnt0); end
    n_cmp++; if (bus.weight_addr !== 9'd27) begin n_mis++; $display("FAIL single_waddr: got %0d expected 27", bus.weight_addr); end
    n_cmp++; if (bus.data_addr !== 4'd5 || bus.data_valid !== 1'b1) begin n_mis++; $display("FAIL single_data: got addr=%0d dv=%b expected 5 1", bus.data_addr, bus.data_valid); end
    bus.bias_ready = 1;
    #1;
    n_cmp++; if (bus.bias_ready0 !== 1'b1) begin n_mis++; $display("FAIL single_bias_ready0: got %b expected 1", bus.bias_ready0); end
    tick();
    bus.bias_ready = 0;
    n_cmp++; if (bus.gnt0 !== 1'b0 || bus.owner !== 1'b0) begin n_mis++; $display("FAIL single_release: got gnt0=%b owner=%b expected 0 0", bus.gnt0, bus.owner); end
    n_cmp++; if (bus.weight_addr !== 9'd0 || bus.data_valid !== 1'b0) begin n_mis++; $display("FAIL single_idle_mux: got waddr=%0d dv=%b expected 0 0", bus.weight_addr, bus.data_valid); end
    tick();
    n_cmp++; if (bus.gnt0 !== 1'b1) begin n_mis++; $display("FAIL single_regrant: got %b expected 1", bus.gnt0); end
    bus.req0 = 0;
    tick();
    n_cmp++; if (bus.gnt0 !== 1'b0) begin n_mis++; $display("FAIL single_abort: got %b expected 0", bus.gnt0); end
    clear_inputs();
    $display("test_single_grant done");
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    bus.req0 = 1; bus.req1 = 1; bus.waddr0 = 9'd100; bus.waddr1 = 9'd200;
    for (int n = 0; n < 4; n++) begin
      logic [1:0] exp_gnt;
      logic [8:0] exp_addr;
      exp_gnt  = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (n % 2 == 0) ? 9'd100 : 9'd200;
      tick();
      for (int c = 0; c < 26; c++) begin
        n_cmp++; if ({bus.gnt1, bus.gnt0} !== exp_gnt || bus.weight_addr !== exp_addr)
          begin n_mis++; $display("FAIL b2b_own n=%0d c=%0d: got gnt=%b waddr=%0d expected %b %0d", n, c, {bus.gnt1, bus.gnt0}, bus.weight_addr, exp_gnt, exp_addr); end
        if (c == 25) bus.bias_ready = 1;
        tick();
      end
      bus.bias_ready = 0;
      n_cmp++; if ({bus.gnt1, bus.gnt0} !== 2'b00 || bus.owner !== exp_gnt[1])
        begin n_mis++; $display("FAIL b2b_bubble n=%0d: got gnt=%b owner=%b expected 00 %b", n, {bus.gnt1, bus.gnt0}, bus.owner, exp_gnt[1]); end
      $display("b2b neuron %0d granted to %0d", n, exp_gnt[1]);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();
    clear_inputs();
    $display("test_back_to_back done");
  endtask

  task automatic test_gating_and_abort();
    // owner is 1 here, so requester 0 wins the tie
    bus.req0 = 1; bus.req1 = 1;
    bus.bvalid0 = 0; bus.bsel0 = 4'd2; bus.bvalid1 = 1; bus.bsel1 = 4'd7;
    tick();
    n_cmp++; if (bus.gnt0 !== 1'b1) begin n_mis++; $display("FAIL gate_gnt0: got %b expected 1", bus.gnt0); end
    bus.mac_ready = 1;
    #1;
    n_cmp++; if (bus.mac_ready0 !== 1'b1 || bus.mac_ready1 !== 1'b0) begin n_mis++; $display("FAIL gate_mac: got r0=%b r1=%b expected 1 0", bus.mac_ready0, bus.mac_ready1); end
    n_cmp++; if (bus.bias_valid !== 1'b0 || bus.bias_sel !== 4'd2) begin n_mis++; $display("FAIL gate_bias_mux: got bv=%b sel=%0d expected 0 2", bus.bias_valid, bus.bias_sel); end
    bus.bias_ready = 1;
    #1;
    n_cmp++; if (bus.bias_ready0 !== 1'b1 || bus.bias_ready1 !== 1'b0) begin n_mis++; $display("FAIL gate_bias_ready: got r0=%b r1=%b expected 1 0", bus.bias_ready0, bus.bias_ready1); end
    tick();
    bus.mac_ready = 0; bus.bias_ready = 0;
    n_cmp++; if ({bus.gnt1, bus.gnt0} !== 2'b00) begin n_mis++; $display("FAIL gate_bubble: got %b expected 00", {bus.gnt1, bus.gnt0}); end
    tick();
    n_cmp++; if (bus.gnt1 !== 1'b1 || bus.bias_valid !== 1'b1 || bus.bias_sel !== 4'd7)
      begin n_mis++; $display("FAIL gate_pending1: got gnt1=%b bv=%b sel=%0d expected 1 1 7", bus.gnt1, bus.bias_valid, bus.bias_sel); end
    tick();
    n_cmp++; if (bus.gnt1 !== 1'b1) begin n_mis++; $display("FAIL abort_hold: got %b expected 1", bus.gnt1); end
    bus.req1 = 0;
    tick();
    n_cmp++; if ({bus.gnt1, bus.gnt0} !== 2'b00 || bus.owner !== 1'b1)
      begin n_mis++; $display("FAIL abort_idle: got gnt=%b owner=%b expected 00 1", {bus.gnt1, bus.gnt0}, bus.owner); end
    bus.bias_ready = 1;
    #1;
    n_cmp++; if ({bus.bias_ready1, bus.bias_ready0} !== 2'b00) begin n_mis++; $display("FAIL idle_bias_ready: got %b expected 00", {bus.bias_ready1, bus.bias_ready0}); end
    tick();
    bus.bias_ready = 0;
    n_cmp++; if (bus.gnt0 !== 1'b1) begin n_mis++; $display("FAIL abort_pending0: got %b expected 1", bus.gnt0); end
    bus.req0 = 0;
    tick();
    clear_inputs();
    $display("test_gating_and_abort done");
  endtask

`ifdef FC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.req0 = 1;
    tick();
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (bus.gnt0 !== 1'b1 || bus.err !== 1'b0)
        begin n_mis++; $display("FAIL wd_hold c=%0d: got gnt0=%b err=%b expected 1 0", c, bus.gnt0, bus.err); end
      tick();
    end
    n_cmp++; if (bus.gnt0 !== 1'b0 || bus.err !== 1'b1)
      begin n_mis++; $display("FAIL wd_expire: got gnt0=%b err=%b expected 0 1", bus.gnt0, bus.err); end
    bus.req0 = 0;
    tick();
    n_cmp++; if (bus.err !== 1'b1) begin n_mis++; $display("FAIL wd_sticky: got %b expected 1", bus.err); end
    bus.err_clr = 1;
    tick();
    bus.err_clr = 0;
    n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL wd_clear: got %b expected 0", bus.err); end
    $display("test_timeout done");
  endtask
`endif

  task automatic test_reset_mid_neuron();
    bus.req1 = 1; bus.dvalid1 = 1; bus.daddr1 = 4'd9;
    tick();
    n_cmp++; if (bus.gnt1 !== 1'b1 || bus.data_valid !== 1'b1) begin n_mis++; $display("FAIL rstmid_own1: got gnt1=%b dv=%b expected 1 1", bus.gnt1, bus.data_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt1 !== 1'b0 || bus.owner !== 1'b1) begin n_mis++; $display("FAIL rstmid_state: got gnt1=%b owner=%b expected 0 1", bus.gnt1, bus.owner); end
    n_cmp++; if (bus.data_valid !== 1'b0 || bus.data_addr !== 4'd0) begin n_mis++; $display("FAIL rstmid_mux: got dv=%b daddr=%0d expected 0 0", bus.data_valid, bus.data_addr); end
    clear_inputs();
    #1;
    rst_n = 1'b1;
    tick();
    $display("test_reset_mid_neuron done");
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_gating_and_abort();
`ifdef FC_ARB_TIMEOUT_EN
    test_timeout();
`else
    n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL err_tied: got %b expected 0", bus.err); end
`endif
    test_reset_mid_neuron();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
